// File: rtl/game_timer_ctrl_pkg.sv
// Shared constants for the game timer: FSM state codes, clock default,
// default time limit, HUD colours, and a 3-digit BCD increment helper.
package game_timer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int          CLK_FREQ_DEF   = 25_000_000;
  localparam logic [11:0] TIME_LIMIT_DEF = 12'h999;

  // RGB565 colours used by the HUD renderer next to the timer digits.
  localparam logic [15:0] HUD_COL_TEXT   = 16'hFFFF;
  localparam logic [15:0] HUD_COL_WARN   = 16'hF800;
  localparam logic [15:0] HUD_COL_BORDER = 16'h07E0;
  localparam logic [15:0] HUD_COL_BG     = 16'h0000;

  // Value the live counter would take after one increment; used to detect
  // the limit in the same cycle as the increment.
  function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4] = 4'd0;
        if (v[11:8] == 4'd9) r[11:8] = 4'd0;
        else                 r[11:8] = v[11:8] + 4'd1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_timer_ctrl_bcd_digit.sv
// One decimal digit (0-9) with synchronous clear and ripple carry output.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_in,
  input  logic       clr,
  output logic [3:0] digit_o,
  output logic       carry_out
);

  logic [3:0] digit_q, digit_d;

  // Carry fires when this digit is asked to step past 9.
  assign carry_out = inc_in && (digit_q == 4'd9);
  assign digit_o   = digit_q;

  // Next digit: clear wins, then increment with wrap 9 -> 0.
  always_comb begin
    digit_d = digit_q;
    if (clr)         digit_d = 4'd0;
    else if (inc_in) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= 4'd0;
    else     digit_q <= digit_d;
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Game timer: IDLE/RUN/PAUSE/DONE control, one-second prescaler, 3-digit BCD
// live counter with limit detection, and a frame-synchronous display shadow.
module game_timer_ctrl
  import game_timer_ctrl_pkg::*;
#(
  parameter int          CLK_FREQ   = CLK_FREQ_DEF,
  parameter logic [11:0] TIME_LIMIT = TIME_LIMIT_DEF
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic       game_start,
  input  logic       game_pause,
  input  logic       game_over,
  input  logic       frame_start,
  output logic [3:0] time_1s,
  output logic [3:0] time_10s,
  output logic [3:0] time_100s,
  output logic       tick_1s,
  output logic       time_up,
  output logic [1:0] state_o
);

  localparam int            PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          time_up_q, time_up_d;
  logic          tick_q;
  logic [11:0]   shadow_q;

  logic [3:0]  d0, d1, d2;
  logic        c0, c1, c2;
  logic [11:0] live, live_nxt;
  logic        at_limit, inc_ev, limit_ev;

  assign live     = {d2, d1, d0};
  assign live_nxt = bcd3_inc(live);
  assign at_limit = (live == TIME_LIMIT);

  // The counter is frozen at the limit (and at 999) so it can never overshoot
  // or wrap, even if a pause deferred the transition to DONE.
  assign inc_ev = (state_q == ST_RUN) && (presc_q == PRESC_MAX) &&
                  !game_over && !game_start && !at_limit && (live != 12'h999);

  // Limit reached by this increment, or already sitting at the limit in RUN
  // (possible after a pause coincided with the limiting increment).
  assign limit_ev = (state_q == ST_RUN) &&
                    (at_limit || (inc_ev && ((live_nxt == TIME_LIMIT) || c2)));

  bcd_digit u_ones     (.clk(vga_clk), .rst(sys_rst), .inc_in(inc_ev), .clr(game_start),
                        .digit_o(d0), .carry_out(c0));
  bcd_digit u_tens     (.clk(vga_clk), .rst(sys_rst), .inc_in(c0), .clr(game_start),
                        .digit_o(d1), .carry_out(c1));
  bcd_digit u_hundreds (.clk(vga_clk), .rst(sys_rst), .inc_in(c1), .clr(game_start),
                        .digit_o(d2), .carry_out(c2));

  // FSM next state and time-up flag, priority over > start > pause > limit.
  always_comb begin
    state_d   = state_q;
    time_up_d = time_up_q;
    if (game_over) begin
      state_d = ST_DONE;
    end else if (game_start) begin
      state_d   = ST_RUN;
      time_up_d = 1'b0;
    end else if (game_pause && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (game_pause && (state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
    end else if (limit_ev) begin
      state_d   = ST_DONE;
      time_up_d = 1'b1;
    end
  end

  // Prescaler advances only in RUN and wraps once per game second.
  always_comb begin
    presc_d = presc_q;
    if (game_start)              presc_d = '0;
    else if (state_q == ST_RUN)  presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
  end

  // Control, tick and display shadow registers.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      time_up_q <= 1'b0;
      tick_q    <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_up_q <= time_up_d;
      tick_q    <= inc_ev;
      if (frame_start) shadow_q <= live;
    end
  end

  assign time_1s   = shadow_q[3:0];
  assign time_10s  = shadow_q[7:4];
  assign time_100s = shadow_q[11:8];
  assign tick_1s   = tick_q;
  assign time_up   = time_up_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Randomized bench for game_timer_ctrl against a decimal behavioural model.
module tb_game_timer_ctrl;

  localparam int          F       = 4;
  localparam logic [11:0] LIM     = 12'h012;
  localparam int          LIM_DEC = 12;

  logic       vga_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       game_start = 1'b0, game_pause = 1'b0, game_over = 1'b0, frame_start = 1'b0;
  logic [3:0] time_1s, time_10s, time_100s;
  logic       tick_1s, time_up;
  logic [1:0] state_o;

  game_timer_ctrl #(.CLK_FREQ(F), .TIME_LIMIT(LIM)) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .game_start(game_start),
    .game_pause(game_pause), .game_over(game_over), .frame_start(frame_start),
    .time_1s(time_1s), .time_10s(time_10s), .time_100s(time_100s),
    .tick_1s(tick_1s), .time_up(time_up), .state_o(state_o)
  );

  always #5 vga_clk = ~vga_clk;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 run, 2 pause, 3 done; seconds kept as plain decimal.
  int m_mode, m_sec, m_pre, m_tu, m_sh, m_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state_o), 32'(m_mode));
    chk({tag, ".tick"},  32'(tick_1s), 32'(m_tick));
    chk({tag, ".tup"},   32'(time_up), 32'(m_tu));
    chk({tag, ".disp"},  32'({time_100s, time_10s, time_1s}), 32'(to_bcd(m_sh)));
  endtask

  task automatic model_reset();
    m_mode = 0; m_sec = 0; m_pre = 0; m_tu = 0; m_sh = 0; m_tick = 0;
  endtask

  // Apply one cycle of inputs, advance the model, check after the edge.
  task automatic step(input bit st, input bit ps, input bit ov, input bit fr, input string tag);
    int  n_mode, n_sec, n_pre, n_tu, n_sh;
    bit  inc;
    game_start = st; game_pause = ps; game_over = ov; frame_start = fr;
    inc    = (m_mode == 1) && (m_pre == F - 1) && !ov && !st && (m_sec < LIM_DEC);
    n_sec  = st ? 0 : (inc ? m_sec + 1 : m_sec);
    n_pre  = st ? 0 : ((m_mode == 1) ? (m_pre + 1) % F : m_pre);
    n_sh   = fr ? m_sec : m_sh;
    n_mode = m_mode;
    n_tu   = m_tu;
    if (ov) n_mode = 3;
    else if (st) begin n_mode = 1; n_tu = 0; end
    else if (ps && m_mode == 1) n_mode = 2;
    else if (ps && m_mode == 2) n_mode = 1;
    else if (m_mode == 1 && n_sec == LIM_DEC) begin n_mode = 3; n_tu = 1; end
    @(posedge vga_clk);
    m_mode = n_mode; m_sec = n_sec; m_pre = n_pre; m_tu = n_tu; m_sh = n_sh;
    m_tick = inc ? 1 : 0;
    @(negedge vga_clk);
    game_start = 0; game_pause = 0; game_over = 0; frame_start = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge vga_clk);
    check_all("reset");
    sys_rst = 1'b0;

    // Directed opening: start, run past the carry, show it on a frame.
    step(1, 0, 0, 0, "start");
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, "run");
    step(0, 0, 0, 1, "frame10");
    step(0, 1, 0, 0, "pause");
    for (int i = 0; i < 20; i++) step(0, 0, 0, (i == 10), "paused");
    step(0, 1, 0, 0, "resume");
    for (int i = 0; i < 20; i++) step(0, 0, 0, (i % 5 == 0), "tolimit");
    step(0, 1, 0, 1, "pause_done");
    step(1, 0, 1, 0, "over_start");
    step(0, 1, 0, 1, "pause_in_done");
    step(1, 0, 0, 1, "restart");

    // Randomized traffic with a mid-count asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) begin
        step(1, 0, 0, 0, "pre_rst_start");
        for (int k = 0; k < 60 && m_sec != 5; k++) step(0, 0, 0, 0, "to5");
        chk("at5", 32'(m_sec), 32'd5);
        #2 sys_rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(negedge vga_clk);
        check_all("rst_hold");
        sys_rst = 1'b0;
        step(0, 1, 0, 1, "idle_pause");
        step(1, 0, 0, 0, "post_rst_start");
      end
      step($urandom_range(0, 149) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
